// File: rtl/pkt_sched_pkg.sv
// Shared types and helpers for the packet round-robin scheduler.
//   state_e : scheduler FSM states (IDLE arbitrates, XFER moves one packet)
//   clog2   : ceiling log2, used for index and counter widths
package pkt_sched_pkg;

  localparam int unsigned DEFAULT_NUM_SRC       = 4;
  localparam int unsigned DEFAULT_PACKET_LENGTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((result < 32) && ((64'd1 << result) < 64'(value))) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req        : request vector, one bit per source
//   last_grant : index granted most recently; search starts just after it
//   grant_c    : winning index (valid when any_req_c)
//   any_req_c  : at least one request present
module rr_arbiter
  import pkt_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEFAULT_NUM_SRC
) (
  input  logic [NUM_SRC-1:0]        req,
  input  logic [clog2(NUM_SRC)-1:0] last_grant,
  output logic [clog2(NUM_SRC)-1:0] grant_c,
  output logic                      any_req_c
);

  localparam int unsigned IDX_W = clog2(NUM_SRC);

  logic [IDX_W-1:0] cand;

  // Scan last_grant+1 .. last_grant+NUM_SRC (mod NUM_SRC); first hit wins.
  always_comb begin
    grant_c   = '0;
    any_req_c = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      cand = IDX_W'((32'(last_grant) + off) % NUM_SRC);
      if (!any_req_c && req[cand]) begin
        any_req_c = 1'b1;
        grant_c   = cand;
      end
    end
  end

endmodule

// File: rtl/pkt_rr_scheduler.sv
// Packet-level round-robin scheduler in front of a shared datapath.
// A grant is held from a packet's first beat through its (possibly forced)
// last beat; config_k is captured from the granted source's register at grant.
//   s_tdata/s_tvalid/s_tlast/s_tready : NUM_SRC AXI-Stream sources
//   m_tdata/m_tvalid/m_tready/m_tlast : registered stream to the datapath
//   m_tid    : source index of the beat on m_tdata
//   config_k : k value frozen for the packet in flight
//   cfg_we/cfg_sel/cfg_k : per-source k register write port (clamped)
//   busy     : high while a packet is being transferred
//   len_err  : one-cycle pulse when tlast is forced at PACKET_LENGTH
module pkt_rr_scheduler
  import pkt_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC       = DEFAULT_NUM_SRC,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PACKET_LENGTH = DEFAULT_PACKET_LENGTH,
  parameter int unsigned K_WIDTH       = DATA_WIDTH + 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]    s_tdata,
  input  logic [NUM_SRC-1:0]               s_tvalid,
  input  logic [NUM_SRC-1:0]               s_tlast,
  output logic [NUM_SRC-1:0]               s_tready,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic                             m_tlast,
  output logic [clog2(NUM_SRC)-1:0]        m_tid,
  output logic [K_WIDTH-1:0]               config_k,
  input  logic                             cfg_we,
  input  logic [clog2(NUM_SRC)-1:0]        cfg_sel,
  input  logic [K_WIDTH-1:0]               cfg_k,
  output logic                             busy,
  output logic                             len_err
);

  localparam int unsigned IDX_W = clog2(NUM_SRC);
  localparam int unsigned CNT_W = clog2(PACKET_LENGTH + 1);
  localparam logic [K_WIDTH-1:0] K_MAX       = K_WIDTH'(PACKET_LENGTH);
  localparam logic [CNT_W-1:0]   LAST_CNT    = CNT_W'(PACKET_LENGTH - 1);
  localparam logic [IDX_W-1:0]   RESET_GRANT = IDX_W'(NUM_SRC - 1);

  state_e                  state_q;
  state_e                  state_d;
  logic [IDX_W-1:0]        grant_q;
  logic [IDX_W-1:0]        last_grant_q;
  logic [CNT_W-1:0]        beat_cnt_q;
  logic [K_WIDTH-1:0]      k_reg [NUM_SRC];

  logic [IDX_W-1:0]        arb_grant;
  logic                    arb_any;
  logic                    out_free;
  logic                    in_hs;
  logic                    out_hs;
  logic                    at_limit;
  logic                    eff_last;
  logic [DATA_WIDTH-1:0]   src_data;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .req        (s_tvalid),
    .last_grant (last_grant_q),
    .grant_c    (arb_grant),
    .any_req_c  (arb_any)
  );

  // Output register can take a beat when empty or draining this cycle.
  assign out_free = !m_tvalid || m_tready;
  assign in_hs    = (state_q == XFER) && s_tvalid[grant_q] && out_free;
  assign out_hs   = m_tvalid && m_tready;
  assign at_limit = (beat_cnt_q == LAST_CNT);
  assign eff_last = s_tlast[grant_q] || at_limit;

  // Only the granted source sees ready, and only in XFER.
  always_comb begin
    s_tready = '0;
    if (state_q == XFER) begin
      s_tready[grant_q] = out_free;
    end
  end

  // Data mux for the granted source.
  always_comb begin
    src_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IDX_W'(i)) begin
        src_data = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any)              state_d = XFER;
      XFER:    if (in_hs && eff_last)    state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Grant, counter, config and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant_q      <= '0;
      last_grant_q <= RESET_GRANT;
      beat_cnt_q   <= '0;
      config_k     <= '0;
      m_tdata      <= '0;
      m_tvalid     <= 1'b0;
      m_tlast      <= 1'b0;
      m_tid        <= '0;
      busy         <= 1'b0;
      len_err      <= 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        k_reg[i] <= '0;
      end
    end else begin
      busy    <= (state_d == XFER);
      len_err <= 1'b0;

      // k_reg is read here before any same-cycle write lands, so a write
      // to the granted index in the grant cycle affects the next packet.
      if ((state_q == IDLE) && arb_any) begin
        grant_q      <= arb_grant;
        last_grant_q <= arb_grant;
        config_k     <= k_reg[arb_grant];
        beat_cnt_q   <= '0;
      end

      if (in_hs) begin
        m_tdata    <= src_data;
        m_tid      <= grant_q;
        m_tlast    <= eff_last;
        m_tvalid   <= 1'b1;
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        len_err    <= at_limit && !s_tlast[grant_q];
      end else if (out_hs) begin
        m_tvalid <= 1'b0;
      end

      if (cfg_we && (32'(cfg_sel) < NUM_SRC)) begin
        k_reg[cfg_sel] <= (cfg_k > K_MAX) ? K_MAX : cfg_k;
      end
    end
  end

endmodule

// File: tb/tb_pkt_rr_scheduler.sv
// Scoreboard bench for pkt_rr_scheduler: stimulus pushes source beats and the
// expected output beats; a monitor pops and compares on every output handshake.
module tb_pkt_rr_scheduler;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned PL      = 8;
  localparam int unsigned KW      = 9;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } src_beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    tid;
    logic          last;
    logic [KW-1:0] k;
    logic          lerr;
  } exp_beat_t;

  logic                  clk;
  logic                  reset_n;
  logic [NUM_SRC*DW-1:0] s_tdata;
  logic [NUM_SRC-1:0]    s_tvalid;
  logic [NUM_SRC-1:0]    s_tlast;
  logic [NUM_SRC-1:0]    s_tready;
  logic [DW-1:0]         m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;
  logic [1:0]            m_tid;
  logic [KW-1:0]         config_k;
  logic                  cfg_we;
  logic [1:0]            cfg_sel;
  logic [KW-1:0]         cfg_k;
  logic                  busy;
  logic                  len_err;

  src_beat_t srcq [NUM_SRC][$];
  exp_beat_t exp_q [$];
  int n_checks;
  int n_fail;
  int beats_seen;
  int pkts_seen;
  int lerr_cnt;

  pkt_rr_scheduler #(
    .NUM_SRC       (NUM_SRC),
    .DATA_WIDTH    (DW),
    .PACKET_LENGTH (PL),
    .K_WIDTH       (KW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .config_k (config_k),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_k    (cfg_k),
    .busy     (busy),
    .len_err  (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
    check({tag, "_m_tlast"},  32'(m_tlast),  32'd0);
    check({tag, "_m_tdata"},  32'(m_tdata),  32'd0);
    check({tag, "_m_tid"},    32'(m_tid),    32'd0);
    check({tag, "_config_k"}, 32'(config_k), 32'd0);
    check({tag, "_s_tready"}, 32'(s_tready), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_len_err"},  32'(len_err),  32'd0);
  endtask

  // Source model: present queue head; pop after an observed handshake.
  task automatic driver_loop();
    logic [NUM_SRC-1:0] fire;
    forever begin
      @(negedge clk);
      fire = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (fire[i] && (srcq[i].size() > 0)) void'(srcq[i].pop_front());
        if (srcq[i].size() > 0) begin
          s_tvalid[i]         = 1'b1;
          s_tdata[i*DW +: DW] = srcq[i][0].data;
          s_tlast[i]          = srcq[i][0].last;
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end
      end
    end
  endtask

  // Monitor: every output handshake is compared against the scoreboard head.
  task automatic monitor_loop();
    exp_beat_t e;
    forever begin
      @(negedge clk);
      if (reset_n && len_err) lerr_cnt++;
      if (reset_n && m_tvalid && m_tready) begin
        beats_seen++;
        if (m_tlast) pkts_seen++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got data=0x%0h tid=%0d last=%0d, expected no beat",
                   m_tdata, m_tid, m_tlast);
        end else begin
          e = exp_q.pop_front();
          if ({m_tdata, m_tid, m_tlast, config_k, len_err} !== {e.data, e.tid, e.last, e.k, e.lerr}) begin
            n_fail++;
            $display("FAIL beat: got data=0x%0h tid=%0d last=%0d k=%0d lerr=%0d, expected data=0x%0h tid=%0d last=%0d k=%0d lerr=%0d",
                     m_tdata, m_tid, m_tlast, config_k, len_err, e.data, e.tid, e.last, e.k, e.lerr);
          end
        end
      end
    end
  endtask

  task automatic push_pkt(input int src, input int n, input logic [7:0] base, input logic last_at_end);
    for (int j = 0; j < n; j++) begin
      srcq[src].push_back('{data: base + 8'(j), last: (j == n - 1) && last_at_end});
    end
  endtask

  task automatic expect_beat(input int tid, input logic [7:0] data, input logic last,
                             input int k, input logic lerr);
    exp_q.push_back('{data: data, tid: 2'(tid), last: last, k: KW'(k), lerr: lerr});
  endtask

  task automatic expect_pkt(input int src, input int n, input logic [7:0] base, input int k);
    for (int j = 0; j < n; j++) begin
      expect_beat(src, base + 8'(j), (j == n - 1), k, 1'b0);
    end
  endtask

  task automatic cfg_write(input int sel, input int k);
    cfg_we  = 1'b1;
    cfg_sel = 2'(sel);
    cfg_k   = KW'(k);
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int cyc;
    cyc = 0;
    while ((exp_q.size() > 0) && (cyc < budget)) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d beats outstanding after %0d cycles, expected 0", name, exp_q.size(), cyc);
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_beats(input string name, input int target, input int budget);
    int cyc;
    cyc = 0;
    while ((beats_seen < target) && (cyc < budget)) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 32'(beats_seen >= target), 32'd1);
  endtask

  initial begin
    int base;
    int cyc;
    reset_n = 1'b0;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0;
    m_tready = 1'b1;
    cfg_we = 1'b0; cfg_sel = '0; cfg_k = '0;
    n_checks = 0; n_fail = 0; beats_seen = 0; pkts_seen = 0; lerr_cnt = 0;
    fork
      driver_loop();
      monitor_loop();
    join_none

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Four simultaneous 3-beat packets, k = 1..4, served 0,1,2,3.
    cfg_write(0, 1); cfg_write(1, 2); cfg_write(2, 3); cfg_write(3, 4);
    for (int s = 0; s < 4; s++) begin
      expect_pkt(s, 3, 8'(8'h10 * (s + 1)), s + 1);
      push_pkt(s, 3, 8'(8'h10 * (s + 1)), 1'b1);
    end
    wait_drain("rr_four_sources", 200);

    // 10-beat packet: tlast forced on beat 8, then beats 9-10 as a new packet.
    for (int j = 0; j < 10; j++) begin
      expect_beat(2, 8'h20 + 8'(j), (j == 7) || (j == 9), 3, (j == 7));
    end
    push_pkt(2, 10, 8'h20, 1'b1);
    wait_drain("forced_tlast", 200);
    check("len_err_pulses", 32'(lerr_cnt), 32'd1);

    // Backpressure mid-packet for 5 cycles.
    base = beats_seen;
    expect_pkt(1, 6, 8'h30, 2);
    push_pkt(1, 6, 8'h30, 1'b1);
    wait_beats("stall_reach", base + 2, 100);
    @(posedge clk);
    #1 m_tready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_m_tvalid", 32'(m_tvalid), 32'd1);
      check("stall_m_tdata", 32'(m_tdata), (exp_q.size() > 0) ? 32'(exp_q[0].data) : 32'hFFFF);
      check("stall_s_tready", 32'(s_tready), 32'd0);
    end
    @(posedge clk);
    #1 m_tready = 1'b1;
    wait_drain("backpressure", 200);

    // Mid-packet k write applies to the next packet; oversized k is clamped.
    expect_pkt(1, 4, 8'h40, 2);
    expect_pkt(1, 2, 8'h44, 7);
    push_pkt(1, 4, 8'h40, 1'b1);
    push_pkt(1, 2, 8'h44, 1'b1);
    cyc = 0;
    while (!busy && (cyc < 50)) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_in_packet", 32'(busy), 32'd1);
    cfg_write(1, 7);
    @(negedge clk);
    check("k_frozen_mid_packet", 32'(config_k), 32'd2);
    wait_drain("cfg_mid_packet", 200);
    cfg_write(3, 20);
    expect_pkt(3, 1, 8'h48, 8);
    push_pkt(3, 1, 8'h48, 1'b1);
    wait_drain("cfg_clamp", 100);

    // Fairness: 0 and 3 alternate; late source 1 served before 0 repeats.
    base = pkts_seen;
    expect_pkt(0, 2, 8'h50, 1);
    expect_pkt(3, 2, 8'h58, 8);
    expect_pkt(0, 2, 8'h52, 1);
    expect_pkt(1, 2, 8'h5E, 7);
    expect_pkt(3, 2, 8'h5A, 8);
    expect_pkt(0, 2, 8'h54, 1);
    expect_pkt(3, 2, 8'h5C, 8);
    push_pkt(0, 2, 8'h50, 1'b1); push_pkt(0, 2, 8'h52, 1'b1); push_pkt(0, 2, 8'h54, 1'b1);
    push_pkt(3, 2, 8'h58, 1'b1); push_pkt(3, 2, 8'h5A, 1'b1); push_pkt(3, 2, 8'h5C, 1'b1);
    cyc = 0;
    while ((pkts_seen < base + 2) && (cyc < 100)) begin
      @(negedge clk);
      cyc++;
    end
    check("fair_reach", 32'(pkts_seen >= base + 2), 32'd1);
    @(posedge clk);
    #1 push_pkt(1, 2, 8'h5E, 1'b1);
    wait_drain("fairness", 300);

    // Reset mid-packet, then source 0 wins first with k back at 0.
    base = beats_seen;
    expect_pkt(0, 5, 8'h60, 1);
    push_pkt(0, 5, 8'h60, 1'b1);
    wait_beats("reset_reach", base + 2, 100);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    srcq[0].delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_zero("mid_reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    expect_pkt(0, 2, 8'h70, 0);
    expect_pkt(2, 2, 8'h78, 0);
    push_pkt(0, 2, 8'h70, 1'b1);
    push_pkt(2, 2, 8'h78, 1'b1);
    wait_drain("after_reset", 100);
    check("len_err_total", 32'(lerr_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
